// File: rtl/mbyte_alu_seq_pkg.sv
// Shared encodings for the multi-byte sequential ALU: request opcodes,
// 8-bit ALU opcodes and controller states.
package mbyte_alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7,
        OP_SHL = 4'd8,
        OP_RCL = 4'd9,
        OP_SHR = 4'd10,
        OP_RCR = 4'd11
    } op_e;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b01000,
        ALU_ADC = 5'b01010,
        ALU_SUB = 5'b01011,
        ALU_SBB = 5'b01101,
        ALU_AND = 5'b10000,
        ALU_OR  = 5'b10001,
        ALU_XOR = 5'b10010,
        ALU_NOT = 5'b10011,
        ALU_SHR = 5'b11000,
        ALU_RCR = 5'b11001,
        ALU_RCL = 5'b11010,
        ALU_SHL = 5'b11011
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Codes 12..15 are reserved and never start an operation.
    function automatic logic is_legal(input logic [3:0] code);
        return code <= OP_RCR;
    endfunction

endpackage

// File: rtl/mbyte_alu_seq_alu.sv
// Combinational 8-bit ALU. For subtraction the carry output means
// "no borrow", and the carry input of SBB is a borrow.
module mbyte_alu_seq_alu
    import mbyte_alu_seq_pkg::*;
(
    input  logic [7:0] i_x,
    input  logic [7:0] i_t,
    input  alu_op_e    i_op,
    input  logic       i_cy,
    output logic [7:0] o_r_c,
    output logic       o_cy_c
);

    always_comb begin
        o_r_c  = 8'h00;
        o_cy_c = 1'b0;
        case (i_op)
            ALU_ADD: {o_cy_c, o_r_c} = {1'b0, i_x} + {1'b0, i_t};
            ALU_ADC: {o_cy_c, o_r_c} = {1'b0, i_x} + {1'b0, i_t} + {8'd0, i_cy};
            ALU_SUB: {o_cy_c, o_r_c} = {1'b0, i_x} + {1'b0, ~i_t} + 9'd1;
            ALU_SBB: {o_cy_c, o_r_c} = {1'b0, i_x} + {1'b0, ~i_t} + {8'd0, ~i_cy};
            ALU_AND: o_r_c = i_x & i_t;
            ALU_OR:  o_r_c = i_x | i_t;
            ALU_XOR: o_r_c = i_x ^ i_t;
            ALU_NOT: o_r_c = ~i_x;
            ALU_SHL: {o_cy_c, o_r_c} = {i_x, 1'b0};
            ALU_RCL: {o_cy_c, o_r_c} = {i_x, i_cy};
            ALU_SHR: {o_r_c, o_cy_c} = {1'b0, i_x};
            ALU_RCR: {o_r_c, o_cy_c} = {i_cy, i_x};
            default: ;
        endcase
    end

endmodule

// File: rtl/mbyte_alu_seq.sv
// Multi-byte ALU that walks one byte per cycle through a single 8-bit ALU,
// chaining carries and building {S,Z,Cy} on the way.
module mbyte_alu_seq
    import mbyte_alu_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic [2:0]            flag
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = $clog2(NBYTES);

    state_e          r_state;
    op_e             r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [IW-1:0]   r_cnt;
    logic            r_cin;
    logic            r_c;
    logic            r_nz;

    logic            w_first;
    logic            w_last;
    logic            w_right;
    logic [IW-1:0]   w_idx;
    logic [7:0]      w_x;
    logic [7:0]      w_t;
    alu_op_e         w_alu_op;
    logic            w_cy;
    logic [7:0]      w_alu_r;
    logic            w_alu_cy;
    logic            w_carry_next;
    logic            w_flag_cy;
    logic [W-1:0]    w_acc_next;
    logic            w_nz_next;

    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == IW'(NBYTES - 1));
    assign w_right = (r_op == OP_SHR) || (r_op == OP_RCR);
    assign w_idx   = w_right ? (IW'(NBYTES - 1) - r_cnt) : r_cnt;
    assign w_x     = r_a[{w_idx, 3'b000} +: 8];
    assign w_t     = r_b[{w_idx, 3'b000} +: 8];

    // Map the request onto the per-byte ALU op and its carry input.
    always_comb begin
        w_alu_op = ALU_ADD;
        w_cy     = r_c;
        case (r_op)
            OP_ADD: w_alu_op = w_first ? ALU_ADD : ALU_ADC;
            OP_ADC: begin
                w_alu_op = ALU_ADC;
                w_cy     = w_first ? r_cin : r_c;
            end
            OP_SUB: begin
                w_alu_op = w_first ? ALU_SUB : ALU_SBB;
                w_cy     = ~r_c;
            end
            OP_SBC: begin
                w_alu_op = ALU_SBB;
                w_cy     = w_first ? r_cin : ~r_c;
            end
            OP_AND: w_alu_op = ALU_AND;
            OP_OR:  w_alu_op = ALU_OR;
            OP_XOR: w_alu_op = ALU_XOR;
            OP_NOT: w_alu_op = ALU_NOT;
            OP_SHL: w_alu_op = w_first ? ALU_SHL : ALU_RCL;
            OP_RCL: begin
                w_alu_op = ALU_RCL;
                w_cy     = w_first ? r_cin : r_c;
            end
            OP_SHR: w_alu_op = w_first ? ALU_SHR : ALU_RCR;
            OP_RCR: begin
                w_alu_op = ALU_RCR;
                w_cy     = w_first ? r_cin : r_c;
            end
            default: ;
        endcase
    end

    mbyte_alu_seq_alu u_alu (
        .i_x    (w_x),
        .i_t    (w_t),
        .i_op   (w_alu_op),
        .i_cy   (w_cy),
        .o_r_c  (w_alu_r),
        .o_cy_c (w_alu_cy)
    );

    // Shifted-out bits come straight from the operand byte, not the ALU flag.
    always_comb begin
        w_carry_next = w_alu_cy;
        w_flag_cy    = 1'b0;
        case (r_op)
            OP_SHL, OP_RCL: begin
                w_carry_next = w_x[7];
                w_flag_cy    = w_x[7];
            end
            OP_SHR, OP_RCR: begin
                w_carry_next = w_x[0];
                w_flag_cy    = w_x[0];
            end
            OP_ADD, OP_ADC: w_flag_cy = w_alu_cy;
            OP_SUB, OP_SBC: w_flag_cy = ~w_alu_cy;
            default: ;
        endcase
    end

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[{w_idx, 3'b000} +: 8] = w_alu_r;
    end

    assign w_nz_next = r_nz | (|w_alu_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_cin   <= 1'b0;
            r_c     <= 1'b0;
            r_nz    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flag    <= 3'b000;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && is_legal(op)) begin
                        r_op    <= op_e'(op);
                        r_a     <= a;
                        r_b     <= b;
                        r_cin   <= cin;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_c     <= 1'b0;
                        r_nz    <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_c   <= w_carry_next;
                    r_nz  <= w_nz_next;
                    r_cnt <= r_cnt + IW'(1);
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= w_acc_next;
                        flag    <= {w_acc_next[W-1], ~w_nz_next, w_flag_cy};
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbyte_alu_seq.sv
// Directed bench for mbyte_alu_seq with NBYTES=4: hand-computed results,
// flags, latency, busy length, start filtering and mid-run reset.
module tb_mbyte_alu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [2:0]  flag;

    int checks;
    int failures;

    mbyte_alu_seq #(.NBYTES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag   (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble the inputs, then check timing and outputs.
    task automatic run_op(input string tag, input logic [3:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, input logic t_cin,
                          input logic [31:0] exp_res, input logic [2:0] exp_flag);
        int lat;
        int bcnt;
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        cin   = t_cin;
        tick();
        start = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'h5A5A5A5A;
        cin   = ~t_cin;
        lat   = 0;
        bcnt  = 0;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) bcnt++;
            tick();
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd4);
        check({tag, "_result"}, 64'(result), 64'(exp_res));
        check({tag, "_flag"}, 64'(flag), 64'(exp_flag));
        tick();
        check({tag, "_done_single"}, 64'(done), 64'd0);
        check({tag, "_result_hold"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        int dcnt;
        int bcnt;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 4'd0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flag", 64'(flag), 64'd0);

        run_op("add_ff_1",   4'd0,  32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 3'b000);
        run_op("add_wrap",   4'd0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 3'b011);
        run_op("sub_0_1",    4'd2,  32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 3'b101);
        run_op("sbc_cin",    4'd3,  32'h00000010, 32'h00000010, 1'b1, 32'hFFFFFFFF, 3'b101);
        run_op("adc_cin",    4'd1,  32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 3'b100);
        run_op("shr",        4'd10, 32'h80000001, 32'h00000000, 1'b0, 32'h40000000, 3'b001);
        run_op("rcr_cin",    4'd11, 32'h00000000, 32'h00000000, 1'b1, 32'h80000000, 3'b100);
        run_op("shl",        4'd8,  32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 3'b011);
        run_op("rcl_cin",    4'd9,  32'h80000000, 32'h00000000, 1'b1, 32'h00000001, 3'b001);
        run_op("xor",        4'd6,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 3'b000);
        run_op("and_zero",   4'd4,  32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 3'b010);
        run_op("or",         4'd5,  32'h12000034, 32'h00560000, 1'b0, 32'h12560034, 3'b000);
        run_op("not_a",      4'd7,  32'h0000FFFF, 32'h12345678, 1'b0, 32'hFFFF0000, 3'b100);
        run_op("sub_borrow", 4'd2,  32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 3'b000);

        // Start pulsed during RUN must be ignored: one done, first op's result.
        start = 1'b1; op = 4'd0; a = 32'h00000002; b = 32'h00000003; cin = 1'b0;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; op = 4'd2; a = 32'h00000100; b = 32'h00000001;
        tick();
        start = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 10; n++) begin
            if (done) dcnt++;
            tick();
        end
        check("run_start_done_count", 64'(dcnt), 64'd1);
        check("run_start_result", 64'(result), 64'h00000005);

        // Illegal op never leaves IDLE.
        start = 1'b1; op = 4'd13; a = 32'h11111111; b = 32'h22222222;
        tick();
        start = 1'b0;
        dcnt = 0;
        bcnt = 0;
        for (int n = 0; n < 8; n++) begin
            if (done) dcnt++;
            if (busy) bcnt++;
            tick();
        end
        check("illegal_busy", 64'(bcnt), 64'd0);
        check("illegal_done", 64'(dcnt), 64'd0);
        check("illegal_result_hold", 64'(result), 64'h00000005);

        // Reset in the 2nd RUN cycle aborts the operation.
        start = 1'b1; op = 4'd0; a = 32'h000000FF; b = 32'h00000001;
        tick();
        start = 1'b0;
        tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_flag", 64'(flag), 64'd0);
        dcnt = 0;
        for (int n = 0; n < 8; n++) begin
            if (done) dcnt++;
            tick();
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1; op = 4'd0;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 64'(busy), 64'd0);
        tick();
        check("rst_prio_busy_next", 64'(busy), 64'd0);

        // Operation after reset still works normally.
        run_op("post_rst_add", 4'd0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mbyte_alu_seq.md
MBYTE_ALU_SEQ -- requirements
Module: mbyte_alu_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal range 2..8).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op, input, 4 bits: operation code.
  - 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT A
  - 8 SHL, 9 RCL, 10 SHR, 11 RCR
  - 12-15 illegal
REQ-006 SHALL have port a, input, 8*NBYTES bits: operand A (X side).
REQ-007 SHALL have port b, input, 8*NBYTES bits: operand B (T side).
REQ-008 SHALL have port cin, input, 1 bit: carry-in for ADC and RCL/RCR; borrow-in for SBC.
REQ-009 SHALL have port busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port result, output, 8*NBYTES bits: registered result.
REQ-012 SHALL have port flag, output, 3 bits: {S,Z,Cy}, registered.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
  - IDLE->RUN on start with a legal op; operands and cin are latched in that cycle.
  - RUN lasts exactly NBYTES cycles and processes one byte per cycle through one 8-bit ALU.
  - RUN->DONE after the last byte.
  - DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL hold busy=1 for exactly the NBYTES RUN cycles and assert done=1 only in DONE; done follows the start cycle by NBYTES+1 cycles.
REQ-015 SHALL ignore start when the state is not IDLE, and SHALL ignore start with an illegal op (state stays IDLE, no done).
REQ-016 SHALL process bytes LSB-first for all ops except SHR/RCR, which process MSB-first.
REQ-017 SHALL issue these per-byte ALU ops, where c is the previous byte's carry:
  - ADD: 01000, then 01010 with cy=c.
  - ADC: 01010 on every byte; first byte cy=cin.
  - SUB: 01011, then 01101 with cy=~c.
  - SBC: 01101 on every byte; first byte cy=cin, later bytes cy=~c.
  - AND/OR/XOR/NOT A: 10000/10001/10010/10011.
REQ-018 SHALL issue these per-byte ALU ops for shifts:
  - SHL: 11011, then 11010 with cy = previous byte's X[7].
  - RCL: 11010 on every byte; first byte cy=cin.
  - SHR: 11000, then 11001 with cy = previous byte's X[0].
  - RCR: 11001 on every byte; first byte cy=cin.
  - The controller SHALL take a right-shift carry-out from the operand byte's bit 0, not from the ALU carry flag.
REQ-019 SHALL compute the final flags as follows:
  - Z=1 iff every result byte is zero.
  - S = bit 7 of the MSB result byte.
  - Cy = final carry-out for ADD/ADC; the inverted final ALU carry (borrow) for SUB/SBC; 0 for logic ops; last shifted-out bit for shifts.
REQ-020 SHALL update result and flag only on the RUN->DONE transition and hold them until the next completion.

Reset
REQ-021 SHALL, when rst=1 in any cycle including mid-RUN, enter IDLE next cycle with busy=0, done=0, result=0 and flag=000; the aborted operation never produces done.
REQ-022 SHALL give rst priority over start in the same cycle.

Structure
REQ-023 SHALL take its op codes (4-bit request codes and 5-bit ALU codes) and state encodings from a shared package, e.g. mbyte_alu_pkg.
REQ-024 SHALL instantiate exactly one existing 8-bit alu sub-module as its only datapath; no other arithmetic is permitted beyond carry and zero bookkeeping.

Verification (NBYTES=4)
REQ-025 SHALL cover: ADD 0x000000FF+0x00000001 -> result 0x00000100, flag 000, done 5 cycles after start, busy high for 4 cycles.
REQ-026 SHALL cover: ADD 0xFFFFFFFF+0x00000001 -> result 0x00000000, flag 011; SUB 0x00000000-0x00000001 -> result 0xFFFFFFFF, flag 101.
REQ-027 SHALL cover: SBC 0x00000010-0x00000010 with cin=1 -> result 0xFFFFFFFF, flag 101; ADC 0x7FFFFFFF+0 with cin=1 -> result 0x80000000, flag 100.
REQ-028 SHALL cover: SHR 0x80000001 -> result 0x40000000, flag 001; RCR 0x00000000 with cin=1 -> result 0x80000000, flag 100; SHL 0x80000000 -> result 0x00000000, flag 011.
REQ-029 SHALL cover: start pulsed during RUN is ignored (one done only); start with op=13 gives no busy and no done.
REQ-030 SHALL cover: rst asserted in the 2nd RUN cycle -> next cycle busy=0, result=0, flag=000, and no done pulse follows.
